// File: rtl/can_pkg.sv
// Shared CAN controller definitions: bus levels, eof_tx FSM states and error codes.
// Imported by every block of the controller that touches the bus or reports errors.
package can_pkg;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_CRC_DEL,
    ST_ACK_SLOT,
    ST_ACK_DEL,
    ST_EOF,
    ST_IFS,
    ST_ERR_FLAG,
    ST_ERR_DEL
  } eof_tx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_ACK      = 2'b01,
    ERR_FORM_DEL = 2'b10,
    ERR_FORM_EOF = 2'b11
  } can_err_code_t;

endpackage

// File: rtl/eof_tx_if.sv
// Signal bundle between the bit-timing/CRC side (master) and the frame tail generator (slave).
interface eof_tx_if;
  import can_pkg::*;

  // Handshake: start and bit_tick are single-clk pulses with no ready/backpressure;
  // start is taken only while busy is low, and frame_done/error are one-clk pulses
  // qualified by nothing else, with error_code valid in the same cycle as error.
  logic          bit_tick;
  logic          start;
  logic          RX;
  logic          TX;
  logic          busy;
  logic          EOF_Flag;
  logic          frame_done;
  logic          error;
  can_err_code_t error_code;

  modport master (
    output bit_tick, start, RX,
    input  TX, busy, EOF_Flag, frame_done, error, error_code
  );

  modport slave (
    input  bit_tick, start, RX,
    output TX, busy, EOF_Flag, frame_done, error, error_code
  );

endinterface

// File: rtl/eof_tx.sv
// CAN transmit frame tail: CRC delimiter, ACK slot/delimiter, EOF, intermission,
// plus active error frame generation on ACK or form errors seen on RX.
module eof_tx
  import can_pkg::*;
#(
  parameter int EOF_BITS      = 7,
  parameter int IFS_BITS      = 3,
  parameter int ERR_FLAG_BITS = 6,
  parameter int ERR_DEL_BITS  = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  eof_tx_if.slave       bus,
  output eof_tx_state_t state_dbg
);

  localparam logic [3:0] EOF_LAST  = 4'(EOF_BITS - 1);
  localparam logic [3:0] EOF_CHK   = 4'(EOF_BITS - 2);
  localparam logic [3:0] IFS_LAST  = 4'(IFS_BITS - 1);
  localparam logic [3:0] FLAG_LAST = 4'(ERR_FLAG_BITS - 1);
  localparam logic [3:0] DEL_LAST  = 4'(ERR_DEL_BITS - 1);

  eof_tx_state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          flag_q, flag_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  can_err_code_t code_q, code_d;
  logic          err_path_q, err_path_d;

  logic          err_hit;
  can_err_code_t err_val;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      tx_q       <= RECESSIVE;
      busy_q     <= 1'b0;
      flag_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
      err_path_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      flag_q     <= flag_d;
      done_q     <= done_d;
      err_q      <= err_d;
      code_q     <= code_d;
      err_path_q <= err_path_d;
    end
  end

  // RX sampled on a tick is the level of the bit that is just ending.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    flag_d     = flag_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;
    err_path_d = err_path_q;
    err_hit    = 1'b0;
    err_val    = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          busy_d     = 1'b1;
          err_path_d = 1'b0;
          tx_d       = RECESSIVE;
          state_d    = bus.bit_tick ? ST_CRC_DEL : ST_WAIT_TICK;
        end
      end
      ST_WAIT_TICK: begin
        if (bus.bit_tick) begin
          state_d = ST_CRC_DEL;
          tx_d    = RECESSIVE;
        end
      end
      ST_CRC_DEL: begin
        if (bus.bit_tick) begin
          if (bus.RX == DOMINANT) begin
            err_hit = 1'b1;
            err_val = ERR_FORM_DEL;
          end else begin
            state_d = ST_ACK_SLOT;
            tx_d    = RECESSIVE;
          end
        end
      end
      ST_ACK_SLOT: begin
        if (bus.bit_tick) begin
          if (bus.RX == RECESSIVE) begin
            err_hit = 1'b1;
            err_val = ERR_ACK;
          end else begin
            state_d = ST_ACK_DEL;
            tx_d    = RECESSIVE;
          end
        end
      end
      ST_ACK_DEL: begin
        if (bus.bit_tick) begin
          if (bus.RX == DOMINANT) begin
            err_hit = 1'b1;
            err_val = ERR_FORM_DEL;
          end else begin
            state_d = ST_EOF;
            cnt_d   = 4'd0;
            flag_d  = 1'b0;
            tx_d    = RECESSIVE;
          end
        end
      end
      ST_EOF: begin
        // A dominant last EOF bit is an overload condition, not an error.
        if (bus.bit_tick) begin
          if (bus.RX == DOMINANT && cnt_q <= EOF_CHK) begin
            err_hit = 1'b1;
            err_val = ERR_FORM_EOF;
          end else if (cnt_q == EOF_LAST) begin
            state_d = ST_IFS;
            cnt_d   = 4'd0;
            flag_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_IFS: begin
        if (bus.bit_tick) begin
          if (cnt_q == IFS_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            busy_d  = 1'b0;
            done_d  = !err_path_q;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_ERR_FLAG: begin
        if (bus.bit_tick) begin
          if (cnt_q == FLAG_LAST) begin
            state_d = ST_ERR_DEL;
            cnt_d   = 4'd0;
            tx_d    = RECESSIVE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_ERR_DEL: begin
        // Only recessive bits count: the delimiter waits for the bus to release.
        if (bus.bit_tick && bus.RX == RECESSIVE) begin
          if (cnt_q == DEL_LAST) begin
            state_d = ST_IFS;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        tx_d    = RECESSIVE;
        busy_d  = 1'b0;
        flag_d  = 1'b1;
      end
    endcase

    if (err_hit) begin
      err_d      = 1'b1;
      code_d     = err_val;
      flag_d     = 1'b1;
      state_d    = ST_ERR_FLAG;
      cnt_d      = 4'd0;
      tx_d       = DOMINANT;
      err_path_d = 1'b1;
    end
  end

  assign bus.TX         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.EOF_Flag   = flag_q;
  assign bus.frame_done = done_q;
  assign bus.error      = err_q;
  assign bus.error_code = code_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_eof_tx.sv
// Randomized bench for eof_tx: per-frame RX patterns are scored against a bit-level
// model of the CAN frame tail built from the field layout, not from the FSM.
module tb_eof_tx;
  import can_pkg::*;

  localparam int EOF_BITS      = 7;
  localparam int IFS_BITS      = 3;
  localparam int ERR_FLAG_BITS = 6;
  localparam int ERR_DEL_BITS  = 8;
  localparam int RX_LEN        = 96;

  logic          clk = 1'b0;
  logic          reset_n;
  eof_tx_state_t state_dbg;
  eof_tx_if      bus();

  eof_tx #(
    .EOF_BITS(EOF_BITS), .IFS_BITS(IFS_BITS),
    .ERR_FLAG_BITS(ERR_FLAG_BITS), .ERR_DEL_BITS(ERR_DEL_BITS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [1:0] last_code;
  logic [1:0] exp_q[$];   // per bit after start: {TX, EOF_Flag}
  int         exp_err_bit;
  logic [1:0] exp_code;
  int         exp_nbits;
  logic       rx_a [RX_LEN];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit 0 = CRC delimiter, 1 = ACK slot, 2 = ACK delimiter, 3.. = EOF, then IFS.
  task automatic build_model();
    int e, k, rec;
    exp_q.delete();
    e = -1;
    for (int i = 0; i < 3 + EOF_BITS - 1; i++) begin
      if (rx_a[i] != ((i == 1) ? 1'b0 : 1'b1)) begin
        e = i;
        break;
      end
    end
    if (e < 0) begin
      for (int b = 0; b < 3 + EOF_BITS + IFS_BITS; b++)
        exp_q.push_back({1'b1, (b >= 3 && b < 3 + EOF_BITS) ? 1'b0 : 1'b1});
    end else begin
      for (int b = 0; b <= e; b++) exp_q.push_back({1'b1, (b >= 3) ? 1'b0 : 1'b1});
      for (int b = 0; b < ERR_FLAG_BITS; b++) exp_q.push_back(2'b01);
      k = e + 1 + ERR_FLAG_BITS;
      rec = 0;
      while (rec < ERR_DEL_BITS && k < RX_LEN) begin
        exp_q.push_back(2'b11);
        if (rx_a[k]) rec++;
        k++;
      end
      for (int b = 0; b < IFS_BITS; b++) exp_q.push_back(2'b11);
    end
    exp_code    = (e == 1) ? 2'b01 : ((e >= 3) ? 2'b11 : 2'b10);
    exp_err_bit = e;
    exp_nbits   = exp_q.size();
  endtask

  task automatic make_rx(input int err_bit, input int hold, input bit ovl);
    int lim;
    for (int i = 0; i < RX_LEN; i++) rx_a[i] = ($urandom_range(0, 3) != 0);
    lim = (err_bit < 0) ? 3 + EOF_BITS - 1 : err_bit;
    for (int i = 0; i < lim; i++) rx_a[i] = (i == 1) ? 1'b0 : 1'b1;
    if (err_bit < 0) begin
      if (ovl) rx_a[3 + EOF_BITS - 1] = 1'b0;
    end else begin
      rx_a[err_bit] = (err_bit == 1) ? 1'b1 : 1'b0;
      for (int h = 0; h < hold; h++) rx_a[err_bit + 1 + ERR_FLAG_BITS + h] = 1'b0;
    end
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    bus.bit_tick = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic release_inputs();
    @(negedge clk);
    bus.bit_tick = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic check_bit(input string tag, input int k);
    logic [1:0] nb;
    nb = exp_q[k];
    check({tag, "_tx"},   bus.TX,       nb[1]);
    check({tag, "_flag"}, bus.EOF_Flag, nb[0]);
    check({tag, "_busy"}, bus.busy,     1'b1);
  endtask

  task automatic run_frame(input int err_bit, input int hold, input bit ovl,
                           input bit coinc, input bit extra_start, input int abort_bit);
    make_rx(err_bit, hold, ovl);
    build_model();
    repeat ($urandom_range(1, 3)) @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    if (coinc) bus.bit_tick = 1'b1;
    @(posedge clk);
    #1;
    if (coinc) begin
      check_bit("coinc_start", 0);
    end else begin
      check("start_busy", bus.busy, 1'b1);
      check("start_tx",   bus.TX,   1'b1);
      release_inputs();
      repeat ($urandom_range(1, 4)) @(negedge clk);
      pulse_tick();
      check_bit("tick1", 0);
    end
    release_inputs();
    for (int k = 0; k < exp_nbits; k++) begin
      bus.RX = rx_a[k];
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      check("pulse_clear", {30'd0, bus.error, bus.frame_done}, 32'd0);
      if (extra_start && k == 4) begin
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
      if (k == abort_bit) begin
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_tx",   bus.TX,       1'b1);
        check("abort_busy", bus.busy,     1'b0);
        check("abort_flag", bus.EOF_Flag, 1'b1);
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        last_code = 2'b00;
        return;
      end
      pulse_tick();
      if (k == exp_err_bit) begin
        check("error", bus.error, 1'b1);
        check("error_code", bus.error_code, exp_code);
        last_code = exp_code;
      end else begin
        check("no_error", bus.error, 1'b0);
      end
      if (k == exp_nbits - 1) begin
        check("frame_done", bus.frame_done, (exp_err_bit < 0) ? 1'b1 : 1'b0);
        check("end_busy",   bus.busy,       1'b0);
        check("end_tx",     bus.TX,         1'b1);
        check("end_flag",   bus.EOF_Flag,   1'b1);
        check("code_hold",  bus.error_code, last_code);
      end else begin
        check("mid_done", bus.frame_done, 1'b0);
        check_bit("bit", k + 1);
      end
      release_inputs();
    end
  endtask

  initial begin
    int r, e;
    reset_n      = 1'b0;
    bus.bit_tick = 1'b0;
    bus.start    = 1'b0;
    bus.RX       = 1'b1;
    last_code    = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx",    bus.TX,         1'b1);
    check("rst_busy",  bus.busy,       1'b0);
    check("rst_flag",  bus.EOF_Flag,   1'b1);
    check("rst_done",  bus.frame_done, 1'b0);
    check("rst_err",   bus.error,      1'b0);
    check("rst_code",  bus.error_code, 2'b00);
    check("rst_state", state_dbg,      ST_IDLE);
    @(negedge clk);
    reset_n = 1'b1;

    run_frame(-1, 0, 1'b0, 1'b0, 1'b0, -1);   // clean frame
    run_frame( 1, 0, 1'b0, 1'b0, 1'b0, -1);   // no acknowledge
    run_frame( 5, 0, 1'b0, 1'b0, 1'b0, -1);   // dominant on EOF bit 3
    run_frame(-1, 0, 1'b1, 1'b0, 1'b0, -1);   // dominant on last EOF bit only
    run_frame( 0, 4, 1'b0, 1'b0, 1'b0, -1);   // delimiter stretched by 4 dominant bits
    run_frame(-1, 0, 1'b0, 1'b1, 1'b1, -1);   // start with tick, then start while busy
    run_frame( 1, 0, 1'b0, 1'b0, 1'b0,  4);   // reset during error flag
    run_frame(-1, 0, 1'b0, 1'b0, 1'b0, -1);

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 2);
      e = (r == 0) ? -1 : $urandom_range(0, 8);
      run_frame(e, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
